// File: rtl/id_stage.sv
// Instruction-decode stage: IF/ID register, 32x32 register file, control decode,
// load-use / branch hazard stall and early branch/jump resolution (1-cycle IF/ID, rest combinational).
module id_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PC_if,
  input  logic [31:0] Instruction_if,
  input  logic        IF_flush,
  input  logic        RegWrite_wb,
  input  logic [4:0]  WriteReg_wb,
  input  logic [31:0] WriteData_wb,
  input  logic        MemRead_ex,
  input  logic        RegWrite_ex,
  input  logic [4:0]  WriteReg_ex,
  input  logic        MemRead_mem,
  input  logic        RegWrite_mem,
  input  logic [4:0]  WriteReg_mem,
  input  logic [31:0] ALUResult_mem,
  output logic        Branch,
  output logic        Jump,
  output logic [31:0] JumpAddr,
  output logic        IFWrite,
  output logic [31:0] PC_id,
  output logic [31:0] Instruction_id,
  output logic [31:0] RsData_id,
  output logic [31:0] RtData_id,
  output logic [31:0] Imm_id,
  output logic [4:0]  Rs_id,
  output logic [4:0]  Rt_id,
  output logic [4:0]  Rd_id,
  output logic        RegDst,
  output logic        ALUSrc,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        MemtoReg,
  output logic        RegWrite,
  output logic [1:0]  ALUOp
);
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  logic [31:0] pc_q, pc_d, instr_q, instr_d;
  logic [31:0] rf_q [32];
  logic        stall;

  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    if (!stall) begin
      if (IF_flush) begin
        pc_d    = PC_if;
        instr_d = '0;
      end else begin
        pc_d    = PC_if;
        instr_d = Instruction_if;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q    <= '0;
      instr_q <= '0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (RegWrite_wb && WriteReg_wb != 5'd0) begin
      rf_q[WriteReg_wb] <= WriteData_wb;
    end
  end

  logic [5:0]  opcode;
  logic [4:0]  rs, rt;
  logic [31:0] rs_rd, rt_rd, rs_cmp, rt_cmp, imm_ext, pc_plus4;
  logic        mem_fwd_ok;

  assign opcode = instr_q[31:26];
  assign rs     = instr_q[25:21];
  assign rt     = instr_q[20:16];

  // Write-through: a same-cycle WB write is visible to the ID read.
  assign rs_rd = (rs == 5'd0) ? '0 :
                 (RegWrite_wb && WriteReg_wb == rs) ? WriteData_wb : rf_q[rs];
  assign rt_rd = (rt == 5'd0) ? '0 :
                 (RegWrite_wb && WriteReg_wb == rt) ? WriteData_wb : rf_q[rt];

  // Only a non-load in MEM has its final value available for the branch compare.
  assign mem_fwd_ok = RegWrite_mem && !MemRead_mem && WriteReg_mem != 5'd0;
  assign rs_cmp = (mem_fwd_ok && WriteReg_mem == rs) ? ALUResult_mem : rs_rd;
  assign rt_cmp = (mem_fwd_ok && WriteReg_mem == rt) ? ALUResult_mem : rt_rd;

  logic is_r, is_lw, is_sw, is_beq, is_bne, is_addi, is_j, is_br, uses_rt;
  logic load_use, br_ex, br_mem;

  assign is_r    = opcode == OP_RTYPE;
  assign is_lw   = opcode == OP_LW;
  assign is_sw   = opcode == OP_SW;
  assign is_beq  = opcode == OP_BEQ;
  assign is_bne  = opcode == OP_BNE;
  assign is_addi = opcode == OP_ADDI;
  assign is_j    = opcode == OP_J;
  assign is_br   = is_beq || is_bne;
  assign uses_rt = is_r || is_br || is_sw;

  assign load_use = MemRead_ex && WriteReg_ex != 5'd0 &&
                    (WriteReg_ex == rs || (uses_rt && WriteReg_ex == rt));
  assign br_ex    = is_br && RegWrite_ex && WriteReg_ex != 5'd0 &&
                    (WriteReg_ex == rs || WriteReg_ex == rt);
  assign br_mem   = is_br && MemRead_mem && WriteReg_mem != 5'd0 &&
                    (WriteReg_mem == rs || WriteReg_mem == rt);
  assign stall    = load_use || br_ex || br_mem;

  always_comb begin
    RegDst   = 1'b0;
    ALUSrc   = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    MemtoReg = 1'b0;
    RegWrite = 1'b0;
    ALUOp    = 2'b00;
    if (!stall) begin
      if (is_r) begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
        ALUOp    = 2'b10;
      end
      if (is_lw) begin
        ALUSrc   = 1'b1;
        MemRead  = 1'b1;
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      if (is_sw) begin
        ALUSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      if (is_br) ALUOp = 2'b01;
      if (is_addi) begin
        ALUSrc   = 1'b1;
        RegWrite = 1'b1;
      end
    end
  end

  assign imm_ext  = {{16{instr_q[15]}}, instr_q[15:0]};
  assign pc_plus4 = pc_q + 32'd4;

  assign Branch   = ((is_beq && rs_cmp == rt_cmp) || (is_bne && rs_cmp != rt_cmp)) && !stall;
  assign Jump     = is_j && !stall;
  assign JumpAddr = is_j ? {pc_plus4[31:28], instr_q[25:0], 2'b00}
                         : pc_plus4 + (imm_ext << 2);
  assign IFWrite  = !stall;

  assign PC_id          = pc_q;
  assign Instruction_id = instr_q;
  assign RsData_id      = rs_rd;
  assign RtData_id      = rt_rd;
  assign Imm_id         = imm_ext;
  assign Rs_id          = rs;
  assign Rt_id          = rt;
  assign Rd_id          = instr_q[15:11];
endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: directed scenarios followed by random instruction streams,
// compared against an instruction-level reference model every cycle.
module tb_id_stage;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] PC_if, Instruction_if;
  logic        IF_flush;
  logic        RegWrite_wb;
  logic [4:0]  WriteReg_wb;
  logic [31:0] WriteData_wb;
  logic        MemRead_ex, RegWrite_ex;
  logic [4:0]  WriteReg_ex;
  logic        MemRead_mem, RegWrite_mem;
  logic [4:0]  WriteReg_mem;
  logic [31:0] ALUResult_mem;
  logic        Branch, Jump, IFWrite;
  logic [31:0] JumpAddr, PC_id, Instruction_id, RsData_id, RtData_id, Imm_id;
  logic [4:0]  Rs_id, Rt_id, Rd_id;
  logic        RegDst, ALUSrc, MemRead, MemWrite, MemtoReg, RegWrite;
  logic [1:0]  ALUOp;

  id_stage dut (
    .clk(clk), .reset(reset), .PC_if(PC_if), .Instruction_if(Instruction_if),
    .IF_flush(IF_flush), .RegWrite_wb(RegWrite_wb), .WriteReg_wb(WriteReg_wb),
    .WriteData_wb(WriteData_wb), .MemRead_ex(MemRead_ex), .RegWrite_ex(RegWrite_ex),
    .WriteReg_ex(WriteReg_ex), .MemRead_mem(MemRead_mem), .RegWrite_mem(RegWrite_mem),
    .WriteReg_mem(WriteReg_mem), .ALUResult_mem(ALUResult_mem), .Branch(Branch),
    .Jump(Jump), .JumpAddr(JumpAddr), .IFWrite(IFWrite), .PC_id(PC_id),
    .Instruction_id(Instruction_id), .RsData_id(RsData_id), .RtData_id(RtData_id),
    .Imm_id(Imm_id), .Rs_id(Rs_id), .Rt_id(Rt_id), .Rd_id(Rd_id), .RegDst(RegDst),
    .ALUSrc(ALUSrc), .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
    .RegWrite(RegWrite), .ALUOp(ALUOp)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int miss = 0;

  // Reference state: architectural view of the IF/ID latch and register file.
  logic [31:0] m_pc, m_instr;
  logic [31:0] m_rf [32];
  logic [7:0]  e_ctrl;
  logic        e_branch, e_jump, e_stall;
  logic [31:0] e_jaddr, e_rs, e_rt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] idx);
    if (idx == 0) return 32'd0;
    if (RegWrite_wb && WriteReg_wb == idx) return WriteData_wb;
    return m_rf[idx];
  endfunction

  function automatic logic [31:0] m_cmp(input logic [4:0] idx);
    if (RegWrite_mem && !MemRead_mem && WriteReg_mem != 0 && WriteReg_mem == idx)
      return ALUResult_mem;
    return m_read(idx);
  endfunction

  task automatic model_eval();
    logic [5:0] op;
    logic [4:0] s, t;
    logic       br, rt_used;
    logic [31:0] a, b, off;
    op = m_instr[31:26];
    s  = m_instr[25:21];
    t  = m_instr[20:16];
    br = (op == 6'd4) || (op == 6'd5);
    rt_used = (op == 6'd0) || br || (op == 6'h2b);
    e_stall = (MemRead_ex && WriteReg_ex != 0 && (WriteReg_ex == s || (rt_used && WriteReg_ex == t)))
           || (br && RegWrite_ex && WriteReg_ex != 0 && (WriteReg_ex == s || WriteReg_ex == t))
           || (br && MemRead_mem && WriteReg_mem != 0 && (WriteReg_mem == s || WriteReg_mem == t));
    case (op)
      6'h00:   e_ctrl = 8'b1000_0110;
      6'h23:   e_ctrl = 8'b0110_1100;
      6'h2b:   e_ctrl = 8'b0101_0000;
      6'h04,
      6'h05:   e_ctrl = 8'b0000_0001;
      6'h08:   e_ctrl = 8'b0100_0100;
      default: e_ctrl = 8'b0000_0000;
    endcase
    if (e_stall) e_ctrl = 8'd0;
    a = m_cmp(s);
    b = m_cmp(t);
    e_branch = !e_stall && ((op == 6'd4 && a == b) || (op == 6'd5 && a != b));
    e_jump   = !e_stall && op == 6'd2;
    off = 32'($signed(m_instr[15:0])) * 4;
    if (op == 6'd2) e_jaddr = ((m_pc + 4) & 32'hF000_0000) | (32'(m_instr[25:0]) * 4);
    else            e_jaddr = m_pc + 4 + off;
    e_rs = m_read(s);
    e_rt = m_read(t);
  endtask

  task automatic compare_all();
    chk("pc_id", PC_id, m_pc);
    chk("instr_id", Instruction_id, m_instr);
    chk("ifwrite", 32'(IFWrite), 32'(!e_stall));
    chk("ctrl", 32'({RegDst, ALUSrc, MemRead, MemWrite, MemtoReg, RegWrite, ALUOp}), 32'(e_ctrl));
    chk("branch", 32'(Branch), 32'(e_branch));
    chk("jump", 32'(Jump), 32'(e_jump));
    chk("jumpaddr", JumpAddr, e_jaddr);
    chk("rsdata", RsData_id, e_rs);
    chk("rtdata", RtData_id, e_rt);
    chk("imm", Imm_id, 32'($signed(m_instr[15:0])));
    chk("fields", 32'({Rs_id, Rt_id, Rd_id}), 32'(m_instr[25:11]));
  endtask

  // Called just after a negedge with inputs settled; flush follows the predicted redirect.
  task automatic eval_and_check();
    #1;
    model_eval();
    IF_flush = e_branch | e_jump;
    #1;
    compare_all();
  endtask

  task automatic tick();
    @(posedge clk);
    if (!reset) begin
      m_pc = 0;
      m_instr = 0;
      for (int i = 0; i < 32; i++) m_rf[i] = 0;
    end else begin
      if (RegWrite_wb && WriteReg_wb != 0) m_rf[WriteReg_wb] = WriteData_wb;
      if (!e_stall) begin
        m_pc    = PC_if;
        m_instr = IF_flush ? 32'd0 : Instruction_if;
      end
    end
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0] s, t, d;
    logic [15:0] imm;
    s = 5'($urandom_range(0, 7));
    t = 5'($urandom_range(0, 7));
    d = 5'($urandom_range(0, 7));
    imm = 16'($urandom_range(0, 65535));
    case ($urandom_range(0, 7))
      0: return {6'h00, s, t, d, 5'd0, 6'h20};
      1: return {6'h23, s, t, imm};
      2: return {6'h2b, s, t, imm};
      3: return {6'h04, s, t, imm};
      4: return {6'h05, s, t, imm};
      5: return {6'h08, s, t, imm};
      6: return {6'h02, 26'($urandom)};
      default: return {6'h3f, s, t, imm};
    endcase
  endfunction

  task automatic idle_pipe();
    RegWrite_wb = 0; WriteReg_wb = 0; WriteData_wb = 0;
    MemRead_ex = 0; RegWrite_ex = 0; WriteReg_ex = 0;
    MemRead_mem = 0; RegWrite_mem = 0; WriteReg_mem = 0; ALUResult_mem = 0;
  endtask

  localparam logic [31:0] ADD3 = {6'd0, 5'd5, 5'd0, 5'd3, 5'd0, 6'h20};
  localparam logic [31:0] ADD4 = {6'd0, 5'd2, 5'd3, 5'd4, 5'd0, 6'h20};

  initial begin
    reset = 0; PC_if = 0; Instruction_if = 0; IF_flush = 0;
    idle_pipe();
    e_stall = 0;
    repeat (2) @(posedge clk);
    m_pc = 0; m_instr = 0;
    for (int i = 0; i < 32; i++) m_rf[i] = 0;
    @(negedge clk);
    reset = 1;

    // Post-reset NOP state; fetch add $3,$5,$0 into ID.
    PC_if = 32'h4; Instruction_if = ADD3;
    eval_and_check();
    chk("rst_instr", Instruction_id, 32'd0);
    chk("rst_ifwrite", 32'(IFWrite), 32'd1);
    chk("rst_branch_jump", 32'({Branch, Jump}), 32'd0);
    chk("rst_rsdata", RsData_id, 32'd0);
    tick();

    // Write-through of $5, then a write to $0 that must be discarded.
    RegWrite_wb = 1; WriteReg_wb = 5; WriteData_wb = 32'h1234;
    eval_and_check();
    chk("wb_through", RsData_id, 32'h1234);
    tick();
    WriteReg_wb = 0; WriteData_wb = 32'hDEAD_BEEF;
    eval_and_check();
    chk("r0_write_same", RtData_id, 32'd0);
    chk("r5_stored", RsData_id, 32'h1234);
    tick();
    RegWrite_wb = 0;
    eval_and_check();
    chk("r0_after", RtData_id, 32'd0);

    // Load-use: add $4,$2,$3 in ID behind lw $2 in EX.
    PC_if = 32'h8; Instruction_if = ADD4;
    tick();
    PC_if = 32'hC; Instruction_if = 32'd0;
    MemRead_ex = 1; RegWrite_ex = 1; WriteReg_ex = 2;
    eval_and_check();
    chk("lu_stall", 32'(IFWrite), 32'd0);
    chk("lu_bubble", 32'({RegDst, RegWrite}), 32'd0);
    tick();
    MemRead_ex = 0; RegWrite_ex = 0; WriteReg_ex = 0;
    eval_and_check();
    chk("lu_held", Instruction_id, ADD4);
    chk("lu_resume", 32'(IFWrite), 32'd1);
    chk("lu_regwrite", 32'(RegWrite), 32'd1);

    // beq $1,$1,+3 at 0x10, then the wrong-path instruction is squashed.
    PC_if = 32'h10; Instruction_if = 32'h1021_0003;
    tick();
    PC_if = 32'h14; Instruction_if = 32'h2006_0005;
    eval_and_check();
    chk("beq_taken", 32'(Branch), 32'd1);
    chk("beq_target", JumpAddr, 32'h20);
    tick();
    PC_if = 32'h8; Instruction_if = 32'h0800_0010;
    eval_and_check();
    chk("flush_nop", Instruction_id, 32'd0);
    chk("flush_pc", PC_id, 32'h14);
    tick();

    // j 0x40 at 0x8.
    PC_if = 32'h30; Instruction_if = 32'h14C0_FFFF;
    eval_and_check();
    chk("j_jump", 32'(Jump), 32'd1);
    chk("j_target", JumpAddr, 32'h40);
    tick();

    // bne $6,$0,-1 at 0x30 (refetched after the jump flush) with addi $6 result in MEM.
    PC_if = 32'h30; Instruction_if = 32'h14C0_FFFF;
    eval_and_check();
    tick();
    RegWrite_mem = 1; MemRead_mem = 0; WriteReg_mem = 6; ALUResult_mem = 7;
    PC_if = 32'h34; Instruction_if = 32'd0;
    eval_and_check();
    chk("bne_nostall", 32'(IFWrite), 32'd1);
    chk("bne_taken", 32'(Branch), 32'd1);
    chk("bne_target", JumpAddr, 32'h30);
    tick();
    idle_pipe();

    // Random streams: hazards, forwarding, WB traffic and occasional reset.
    for (int n = 0; n < 600; n++) begin
      reset          = ($urandom_range(0, 49) != 0);
      PC_if          = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      Instruction_if = rand_instr();
      RegWrite_wb    = 1'($urandom_range(0, 1));
      WriteReg_wb    = 5'($urandom_range(0, 7));
      WriteData_wb   = $urandom;
      MemRead_ex     = ($urandom_range(0, 3) == 0);
      RegWrite_ex    = MemRead_ex | ($urandom_range(0, 2) == 0);
      WriteReg_ex    = 5'($urandom_range(0, 7));
      MemRead_mem    = ($urandom_range(0, 3) == 0);
      RegWrite_mem   = MemRead_mem | ($urandom_range(0, 1) == 0);
      WriteReg_mem   = 5'($urandom_range(0, 7));
      ALUResult_mem  = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      eval_and_check();
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule
